comb_fitness_sequencer: RTL

COMB_FITNESS_SEQUENCER -- requirements
Module: comb_fitness_sequencer

---
 rtl/comb_fitness_pkg.sv | 14 +
 rtl/comb_fitness_settle_timer.sv | 29 ++
 rtl/comb_fitness_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/comb_fitness_pkg.sv
// Shared types and sizes for the combinational-candidate fitness sequencer.
package comb_fitness_pkg;
  localparam int N_ROWS = 16;
  localparam int ROW_W  = 4;
  localparam int FIT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;
endpackage

// File: rtl/comb_fitness_settle_timer.sv
// Per-row settle wait: load with the cycle count, tick while waiting, expire on the last tick.
module settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             expire_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (tick_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // The count still reads 1 during the final wait cycle.
  assign expire_o = tick_i && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/comb_fitness_sequencer.sv
// Sweeps all 16 input rows through an external 4-input candidate circuit and scores
// it against a latched target truth table.
module comb_fitness_sequencer
  import comb_fitness_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int N_ROWS        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_ROWS-1:0] target,
  output logic [ROW_W-1:0]  cand_vec,
  input  logic              cand_out,
  output logic              busy,
  output logic              done,
  output logic [FIT_W-1:0]  fitness,
  output logic [N_ROWS-1:0] mismatch_mask,
  output logic              perfect
);
  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [N_ROWS-1:0] tgt_q, tgt_d;
  logic [FIT_W-1:0]  acc_q, acc_d;
  logic [N_ROWS-1:0] mis_q, mis_d;
  logic [FIT_W-1:0]  fitness_q, fitness_d;
  logic [N_ROWS-1:0] mask_q, mask_d;
  logic              perfect_q, perfect_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_tick, tmr_expire;

  settle_timer #(.CNT_W(4)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (4'(SETTLE_CYCLES)),
    .tick_i     (tmr_tick),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    tgt_d     = tgt_q;
    acc_d     = acc_q;
    mis_d     = mis_q;
    fitness_d = fitness_q;
    mask_d    = mask_q;
    perfect_d = perfect_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d   = target;
          acc_d   = '0;
          mis_d   = '0;
          row_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        tmr_tick = 1'b1;
        if (tmr_expire) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        // At most N_ROWS increments per sweep, so the 5-bit accumulator cannot wrap.
        if (cand_out == tgt_q[row_q]) acc_d = acc_q + FIT_W'(1);
        else                          mis_d[row_q] = 1'b1;
        if (row_q == ROW_W'(N_ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        // Results publish together with the done pulse on the edge leaving DONE.
        fitness_d = acc_q;
        mask_d    = mis_q;
        perfect_d = (acc_q == FIT_W'(N_ROWS));
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      tgt_q     <= '0;
      acc_q     <= '0;
      mis_q     <= '0;
      fitness_q <= '0;
      mask_q    <= '0;
      perfect_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      tgt_q     <= tgt_d;
      acc_q     <= acc_d;
      mis_q     <= mis_d;
      fitness_q <= fitness_d;
      mask_q    <= mask_d;
      perfect_q <= perfect_d;
      done_q    <= done_d;
    end
  end

  assign busy          = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign cand_vec      = busy ? row_q : '0;
  assign done          = done_q;
  assign fitness       = fitness_q;
  assign mismatch_mask = mask_q;
  assign perfect       = perfect_q;
endmodule
